btn_event_gen: RTL and testbench
================================

// Module: btn_event_gen
// PURPOSE
//  Consumes the debounced button levels and turns each button into a stream of
//  timed events: PRESS, auto-REPEAT while held, and RELEASE.
//  Events pass to the game-control logic one at a time over a valid/ready handshake.
//  Sits directly downstream of the debouncer; its btn_lvl input is the debounced level bus.
// PARAMETERS
//  BTN_WIDTH    5     number of buttons
//  TICK_DIV     6000  clk cycles per timing tick (1 ms at 6 MHz), >=2
//  DELAY_TICKS  400   ticks from PRESS to first REPEAT, >=1
//  REPEAT_TICKS 100   ticks between successive REPEATs, >=1
//  LONG_TICKS   1000  ticks held before LONG (only with BTN_EVT_LONG_EN), >=1
// PORTS
//  clk        in  1                  system clock
//  rst_n      in  1                  asynchronous reset, active-low
//  btn_lvl    in  BTN_WIDTH          debounced button levels, 1 = pressed
//  evt_valid  out 1                  event available
//  evt_ready  in  1                  consumer accepts event when valid&ready
//  evt_btn    out clog2(BTN_WIDTH)   index of button owning the event
//  evt_kind   out 2                  0 PRESS, 1 REPEAT, 2 RELEASE, 3 LONG
//  evt_drop   out 1                  1-cycle pulse: an event was discarded
// BEHAVIOUR
//  Reset: clk and rst_n are the only clock and reset. rst_n low asynchronously clears
//   all state. Outputs while in reset: evt_valid=0, evt_btn=0, evt_kind=0, evt_drop=0.
//   btn_q=0 on reset, so a button held through reset gives PRESS after release of reset.
//  Tick: shared prescaler counts 0..TICK_DIV-1; tick=1 for one clk when count==TICK_DIV-1.
//  Edge detect: btn_q <= btn_lvl each clk; rise = btn_lvl&~btn_q, fall = ~btn_lvl&btn_q.
//  Per-button FSM (states IDLE, DELAY, REPEAT; tick counter cnt):
//   IDLE:   rise -> emit PRESS, cnt=0, go DELAY.
//   DELAY:  on tick cnt++; tick with cnt==DELAY_TICKS-1 -> emit REPEAT, cnt=0, go REPEAT.
//   REPEAT: on tick cnt++; tick with cnt==REPEAT_TICKS-1 -> emit REPEAT, cnt=0.
//   DELAY/REPEAT: fall -> emit RELEASE, go IDLE (takes priority over a same-cycle tick).
//   First REPEAT lands DELAY_TICKS or DELAY_TICKS-1 ticks after PRESS (tick phase is free-running).
//  Pending slot per button: 1 valid bit + 2-bit kind.
//   RELEASE always writes its slot, overwriting any pending PRESS/REPEAT/LONG; never dropped.
//   PRESS/REPEAT/LONG arriving on a full slot are discarded and evt_drop pulses.
//   Same-cycle pop of slot i and new event for i: pop first, new event fills the slot, no drop.
//  Output: fixed priority, lowest index with a full slot. evt_* decoded from slot registers only.
//   No combinational path from evt_ready to any output.
//   Slot clears on valid&ready. evt_btn/evt_kind stable while valid&~ready unless a RELEASE
//   overwrites the shown slot or a lower-index slot fills. The consumer tolerates this.
//  Latency: btn_lvl high sampled at edge N -> evt_valid=1 with PRESS after edge N+1.
//  Widths: cnt is clog2(max(DELAY,REPEAT,LONG)_TICKS)+1 bits. Prescaler is clog2(TICK_DIV) bits.
// CONFIGURATION
//  `BTN_EVT_LONG_EN defined: per-button hold counter counts ticks from PRESS, saturating at LONG_TICKS.
//   One LONG is emitted exactly when the counter reaches LONG_TICKS; it is emitted once per press.
//   Cleared on fall. LONG and REPEAT on the same cycle: LONG wins the slot, REPEAT counts as a drop.
//  Undefined: no hold counter, kind 3 is never produced, LONG_TICKS is ignored.
// STRUCTURE
//  btn_evt_pkg: KIND_PRESS/REPEAT/RELEASE/LONG localparams, FSM state encodings, clog2 function.
//  btn_evt_fsm: per-button sub-module (edge detect, FSM, cnt, optional hold counter, emit strobe+kind).
//   Instanced BTN_WIDTH times by a generate loop.
//  Top level: prescaler, pending slots, priority arbiter, drop logic.
// TESTING  (sim params TICK_DIV=4, DELAY_TICKS=3, REPEAT_TICKS=2, LONG_TICKS=5, evt_ready=1 unless noted)
//  1 btn_lvl[2] 0->1 and held -> PRESS btn2 2 clks later; REPEATs at ~12 clks, then every 8 clks.
//  2 btn_lvl[0] and btn_lvl[3] rise same clk -> PRESS btn0 then PRESS btn3 on consecutive cycles.
//  3 evt_ready=0, press btn1 then release btn1 -> single pending event RELEASE btn1; evt_drop=0.
//  4 evt_ready=0, hold btn4 past first REPEAT -> evt_drop pulses once, slot still PRESS btn4.
//  5 rst_n low mid-REPEAT for 1 clk -> evt_valid=0 immediately; if held, PRESS re-emitted after reset.
//  6 `BTN_EVT_LONG_EN, hold btn0 25 clks -> exactly one LONG btn0, ~20 clks after PRESS; none when undefined.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg: event kind codes, per-button FSM state codes and width helpers
// shared by btn_event_gen and btn_evt_fsm.
package btn_evt_pkg;
    localparam logic [1:0] KIND_PRESS   = 2'd0;
    localparam logic [1:0] KIND_REPEAT  = 2'd1;
    localparam logic [1:0] KIND_RELEASE = 2'd2;
    localparam logic [1:0] KIND_LONG    = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/btn_evt_fsm.sv
// btn_evt_fsm: one button's edge detect, PRESS/REPEAT/RELEASE tick timer and, with
// BTN_EVT_LONG_EN defined, the LONG hold counter; emits a registered strobe + kind.
module btn_evt_fsm
    import btn_evt_pkg::*;
#(
    parameter int DELAY_TICKS  = 400,
    parameter int REPEAT_TICKS = 100,
    parameter int LONG_TICKS   = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_i,
    input  logic       tick_i,
    output logic       emit_o,
    output logic [1:0] kind_o,
    output logic       coll_o
);
    localparam int CW = clog2(max2(max2(DELAY_TICKS, REPEAT_TICKS), LONG_TICKS)) + 1;
    localparam logic [CW-1:0] DLIM = CW'(DELAY_TICKS - 1);
    localparam logic [CW-1:0] RLIM = CW'(REPEAT_TICKS - 1);

    logic          btn_q, emit_q, coll_q, rise, fall, rep, lng;
    logic [1:0]    st_q, st_d, kind_q;
    logic [CW-1:0] cnt_q, cnt_d;

    assign rise = btn_i & ~btn_q;
    assign fall = ~btn_i & btn_q;

    // Release wins over a same-cycle tick, so a fall never also yields a REPEAT.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        rep   = 1'b0;
        if (st_q == ST_IDLE) begin
            if (rise) begin
                st_d  = ST_DELAY;
                cnt_d = '0;
            end
        end else if (fall) begin
            st_d = ST_IDLE;
        end else if (tick_i) begin
            rep   = cnt_q == ((st_q == ST_DELAY) ? DLIM : RLIM);
            cnt_d = rep ? '0 : cnt_q + 1'b1;
            if (rep) st_d = ST_REPEAT;
        end
    end

`ifdef BTN_EVT_LONG_EN
    localparam logic [CW-1:0] LLIM = CW'(LONG_TICKS);
    logic [CW-1:0] hold_q, hold_d;
    // Saturates at LLIM, so the LONG strobe fires once per press.
    always_comb begin
        hold_d = hold_q;
        lng    = 1'b0;
        if (st_q == ST_IDLE || fall) begin
            hold_d = '0;
        end else if (tick_i && hold_q != LLIM) begin
            hold_d = hold_q + 1'b1;
            lng    = hold_d == LLIM;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) hold_q <= '0;
        else        hold_q <= hold_d;
`else
    assign lng = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q  <= 1'b0;
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            emit_q <= 1'b0;
            kind_q <= KIND_PRESS;
            coll_q <= 1'b0;
        end else begin
            btn_q  <= btn_i;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            emit_q <= (st_q == ST_IDLE) ? rise : (fall | rep | lng);
            kind_q <= (st_q == ST_IDLE) ? KIND_PRESS :
                      fall ? KIND_RELEASE : lng ? KIND_LONG : KIND_REPEAT;
            coll_q <= lng & rep;
        end
    end

    assign emit_o = emit_q;
    assign kind_o = kind_q;
    assign coll_o = coll_q;
endmodule

// File: rtl/btn_event_gen.sv
// btn_event_gen: turns debounced button levels into PRESS/REPEAT/RELEASE events over
// valid/ready; define BTN_EVT_LONG_EN to add one LONG event per sufficiently long hold.
module btn_event_gen
    import btn_evt_pkg::*;
#(
    parameter int BTN_WIDTH    = 5,
    parameter int TICK_DIV     = 6000,
    parameter int DELAY_TICKS  = 400,
    parameter int REPEAT_TICKS = 100,
    parameter int LONG_TICKS   = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BTN_WIDTH-1:0]          btn_lvl,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [clog2(BTN_WIDTH)-1:0]   evt_btn,
    output logic [1:0]                    evt_kind,
    output logic                          evt_drop
);
    localparam int BW = clog2(BTN_WIDTH);
    localparam int PW = clog2(TICK_DIV);
    localparam logic [PW-1:0] PLIM = PW'(TICK_DIV - 1);

    logic [PW-1:0]             pre_q;
    logic                      tick, drop_q;
    logic [BTN_WIDTH-1:0]      emit, coll, pop, ovf, slot_v_q, slot_v_d;
    logic [BTN_WIDTH-1:0][1:0] kind, slot_k_q, slot_k_d;
    logic [BW-1:0]             sel;
    logic [1:0]                sel_k;

    assign tick = pre_q == PLIM;

    for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
        btn_evt_fsm #(
            .DELAY_TICKS (DELAY_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS),
            .LONG_TICKS  (LONG_TICKS)
        ) u_fsm (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_i (btn_lvl[i]),
            .tick_i(tick),
            .emit_o(emit[i]),
            .kind_o(kind[i]),
            .coll_o(coll[i])
        );
    end

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        sel   = '0;
        sel_k = KIND_PRESS;
        for (int i = BTN_WIDTH - 1; i >= 0; i--)
            if (slot_v_q[i]) begin
                sel   = BW'(i);
                sel_k = slot_k_q[i];
            end
    end

    assign evt_valid = |slot_v_q;
    assign evt_btn   = sel;
    assign evt_kind  = sel_k;
    assign evt_drop  = drop_q;

    // A pop frees the slot before a same-cycle event lands; RELEASE always overwrites.
    always_comb begin
        pop      = '0;
        ovf      = '0;
        slot_v_d = slot_v_q;
        slot_k_d = slot_k_q;
        for (int i = 0; i < BTN_WIDTH; i++) begin
            pop[i]      = evt_valid & evt_ready & (sel == BW'(i));
            ovf[i]      = emit[i] & (kind[i] != KIND_RELEASE) & slot_v_q[i] & ~pop[i];
            slot_v_d[i] = emit[i] | (slot_v_q[i] & ~pop[i]);
            slot_k_d[i] = (emit[i] & ~ovf[i]) ? kind[i] : slot_k_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            slot_v_q <= '0;
            slot_k_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            pre_q    <= tick ? '0 : pre_q + 1'b1;
            slot_v_q <= slot_v_d;
            slot_k_q <= slot_k_d;
            drop_q   <= |(ovf | coll);
        end
    end
endmodule

// File: tb/tb_btn_event_gen.sv
// tb_btn_event_gen: directed stimulus for btn_event_gen checked every cycle against a
// tick-count event model, plus literal expectations on latency, ordering and event counts.
module tb_btn_event_gen;
    localparam int NB = 5, TD = 4, DT = 3, RT = 2, LT = 5;
`ifdef BTN_EVT_LONG_EN
    localparam int LONG_EN = 1;
`else
    localparam int LONG_EN = 0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, evt_ready = 1'b1;
    logic [NB-1:0] btn_lvl = '0;
    logic          evt_valid, evt_drop;
    logic [2:0]    evt_btn;
    logic [1:0]    evt_kind;

    int n_chk = 0, n_fail = 0;

    bit m_prev [NB];
    int m_k    [NB];
    bit g_v    [NB];
    int g_kind [NB];
    bit g_coll [NB];
    bit s_v    [NB];
    int s_kind [NB];
    bit e_valid, e_drop;
    int e_btn, e_kind, ecount;
    int acc [NB][4];
    int drops;

    always #5 clk = ~clk;

    btn_event_gen #(
        .BTN_WIDTH(NB), .TICK_DIV(TD), .DELAY_TICKS(DT), .REPEAT_TICKS(RT), .LONG_TICKS(LT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_lvl(btn_lvl), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_btn(evt_btn), .evt_kind(evt_kind), .evt_drop(evt_drop)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clr_stats();
        foreach (acc[i, j]) acc[i][j] = 0;
        drops = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_prev[i] = 0; m_k[i] = 0; g_v[i] = 0; g_kind[i] = 0;
            g_coll[i] = 0; s_v[i] = 0; s_kind[i] = 0;
        end
        e_valid = 0; e_drop = 0; e_btn = 0; e_kind = 0; ecount = 0;
    endtask

    // Events are a function of ticks elapsed since the press; they reach the slots one edge later.
    task automatic model_step();
        bit tick, drop;
        tick = (ecount % TD) == TD - 1;
        ecount++;
        drop = 0;
        if (e_valid && evt_ready) begin
            s_v[e_btn] = 0;
            acc[e_btn][e_kind]++;
        end
        for (int i = 0; i < NB; i++) begin
            if (g_coll[i]) drop = 1;
            if (g_v[i]) begin
                if (g_kind[i] == 2 || !s_v[i]) begin
                    s_v[i] = 1;
                    s_kind[i] = g_kind[i];
                end else drop = 1;
            end
        end
        for (int i = 0; i < NB; i++) begin
            g_v[i] = 0; g_coll[i] = 0;
            if (btn_lvl[i] && !m_prev[i]) begin
                g_v[i] = 1; g_kind[i] = 0; m_k[i] = 0;
            end else if (!btn_lvl[i] && m_prev[i]) begin
                g_v[i] = 1; g_kind[i] = 2;
            end else if (btn_lvl[i] && tick) begin
                bit rep, lng;
                m_k[i]++;
                rep = m_k[i] >= DT && (m_k[i] - DT) % RT == 0;
                lng = LONG_EN != 0 && m_k[i] == LT;
                if (lng) begin
                    g_v[i] = 1; g_kind[i] = 3; g_coll[i] = rep;
                end else if (rep) begin
                    g_v[i] = 1; g_kind[i] = 1;
                end
            end
            m_prev[i] = btn_lvl[i];
        end
        e_drop = drop;
        if (drop) drops++;
        e_valid = 0; e_btn = 0; e_kind = 0;
        for (int i = NB - 1; i >= 0; i--)
            if (s_v[i]) begin
                e_valid = 1; e_btn = i; e_kind = s_kind[i];
            end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("valid", int'(evt_valid), int'(e_valid));
        chk("drop", int'(evt_drop), int'(e_drop));
        if (e_valid) begin
            chk("btn", int'(evt_btn), e_btn);
            chk("kind", int'(evt_kind), e_kind);
        end
    end

    initial begin
        clr_stats();
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_btn", int'(evt_btn), 0);
        chk("rst_kind", int'(evt_kind), 0);
        chk("rst_drop", int'(evt_drop), 0);
        rst_n = 1'b1;

        // 1: PRESS two clocks after the rise, then REPEATs, then RELEASE
        @(negedge clk); btn_lvl[2] = 1'b1;
        @(negedge clk); chk("t1_early_valid", int'(evt_valid), 0);
        @(negedge clk);
        chk("t1_press_valid", int'(evt_valid), 1);
        chk("t1_press_btn", int'(evt_btn), 2);
        chk("t1_press_kind", int'(evt_kind), 0);
        repeat (39) @(negedge clk);
        btn_lvl[2] = 1'b0;
        repeat (6) @(negedge clk);
        chk("t1_n_press", acc[2][0], 1);
        chk("t1_n_repeat", acc[2][1], LONG_EN != 0 ? 3 : 4);
        chk("t1_n_release", acc[2][2], 1);
        chk("t1_n_long", acc[2][3], LONG_EN);

        // 2: simultaneous rises are served lowest index first
        clr_stats();
        btn_lvl = 5'b01001;
        @(negedge clk);
        @(negedge clk);
        chk("t2_first_btn", int'(evt_btn), 0);
        chk("t2_first_kind", int'(evt_kind), 0);
        @(negedge clk);
        chk("t2_second_valid", int'(evt_valid), 1);
        chk("t2_second_btn", int'(evt_btn), 3);
        chk("t2_second_kind", int'(evt_kind), 0);
        btn_lvl = '0;
        repeat (6) @(negedge clk);
        chk("t2_rel0", acc[0][2], 1);
        chk("t2_rel3", acc[3][2], 1);

        // 3: RELEASE overwrites a stalled PRESS without a drop
        clr_stats();
        evt_ready = 1'b0;
        btn_lvl[1] = 1'b1;
        repeat (3) @(negedge clk);
        btn_lvl[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_valid", int'(evt_valid), 1);
        chk("t3_btn", int'(evt_btn), 1);
        chk("t3_kind", int'(evt_kind), 2);
        chk("t3_drops", drops, 0);
        evt_ready = 1'b1;
        @(negedge clk);
        chk("t3_drained", int'(evt_valid), 0);
        chk("t3_n_press", acc[1][0], 0);

        // 4: first REPEAT hits a full slot and is dropped
        clr_stats();
        evt_ready = 1'b0;
        btn_lvl[4] = 1'b1;
        repeat (16) @(negedge clk);
        chk("t4_drops", drops, 1);
        chk("t4_valid", int'(evt_valid), 1);
        chk("t4_btn", int'(evt_btn), 4);
        chk("t4_kind", int'(evt_kind), 0);
        btn_lvl[4] = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_rel_kind", int'(evt_kind), 2);
        evt_ready = 1'b1;
        repeat (3) @(negedge clk);

        // 5: reset mid-REPEAT clears at once; a held button gives a fresh PRESS
        clr_stats();
        btn_lvl[2] = 1'b1;
        repeat (20) @(negedge clk);
        evt_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_pre_valid", int'(evt_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", int'(evt_valid), 0);
        chk("t5_rst_kind", int'(evt_kind), 0);
        chk("t5_rst_btn", int'(evt_btn), 0);
        @(negedge clk);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_press_valid", int'(evt_valid), 1);
        chk("t5_press_btn", int'(evt_btn), 2);
        chk("t5_press_kind", int'(evt_kind), 0);
        btn_lvl[2] = 1'b0;
        repeat (6) @(negedge clk);

        // 6: a long hold yields one LONG only when the feature is built in
        clr_stats();
        btn_lvl[0] = 1'b1;
        repeat (25) @(negedge clk);
        btn_lvl[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_n_long", acc[0][3], LONG_EN);
        chk("t6_n_repeat", acc[0][1], LONG_EN != 0 ? 1 : 2);
        chk("t6_drops", drops, LONG_EN);
        chk("t6_n_release", acc[0][2], 1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
